vdp_reg_loader: RTL and testbench

VDP_REG_LOADER -- requirements
Module: vdp_reg_loader

---
 rtl/vdp_pkg.sv | 29 ++
 rtl/vdp_reg_loader.sv | 182 ++++++++++++++++++
 tb/tb_vdp_reg_loader.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP register loader: state encoding, write-register
// signature and register count, plus the selected-register search helper.
package vdp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_VAL  = 3'd2,
        ST_ADR  = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [1:0] WR_REG_SIG = 2'b10;
    localparam int         NUM_REGS   = 8;

    // Lowest set mask bit at or above 'from'; returns 8 (bit 3 set) when none remain.
    function automatic logic [3:0] next_sel(input logic [7:0] m, input logic [3:0] from);
        logic [3:0] r;
        r = 4'd8;
        for (int i = NUM_REGS - 1; i >= 0; i--) begin
            if (m[i] && (i >= int'(from))) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vdp_reg_loader.sv
// Writes a masked set of VDP registers as value/address tick pairs with a
// programmable idle gap. Optional receiver resync via macro VDP_REG_LOADER_SYNC_EN.
module vdp_reg_loader
    import vdp_pkg::*;
#(
    parameter int GAP = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] mask,
    input  logic [7:0] v0,
    input  logic [7:0] v1,
    input  logic [7:0] v2,
    input  logic [7:0] v3,
    input  logic [7:0] v4,
    input  logic [7:0] v5,
    input  logic [7:0] v6,
    input  logic [7:0] v7,
    output logic       busy,
    output logic       done,
    output logic       wr_tick,
    output logic       rd_tick,
    output logic [7:0] dout
);

    state_t      state_reg, state_next;
    state_t      from_reg, from_next;
    logic [2:0]  idx_reg, idx_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [7:0]  mask_reg, mask_next;
    logic [7:0]  v_in   [NUM_REGS];
    logic [7:0]  v_reg  [NUM_REGS];
    logic [7:0]  v_next [NUM_REGS];

    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        wr_tick_reg, wr_tick_next;
    logic        rd_tick_reg, rd_tick_next;
    logic [7:0]  dout_reg, dout_next;

    logic        accept;
    state_t      src_state;
    logic [3:0]  sel;
    state_t      tgt_state;
    logic [2:0]  tgt_idx;

    assign v_in[0] = v0;
    assign v_in[1] = v1;
    assign v_in[2] = v2;
    assign v_in[3] = v3;
    assign v_in[4] = v4;
    assign v_in[5] = v5;
    assign v_in[6] = v6;
    assign v_in[7] = v7;

    assign accept    = (state_reg == ST_IDLE) && start;
    assign mask_next = accept ? mask : mask_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_latch
            assign v_next[gi] = accept ? v_in[gi] : v_reg[gi];
        end
    endgenerate

    // Where to go once the current tick (and its gap, if any) has finished.
    always_comb begin
        src_state = (state_reg == ST_GAP) ? from_reg : state_reg;
        sel       = next_sel(mask_reg, (src_state == ST_ADR) ? ({1'b0, idx_reg} + 4'd1) : 4'd0);
        tgt_state = sel[3] ? ST_DONE : ST_VAL;
        tgt_idx   = sel[2:0];
        if (src_state == ST_VAL) begin
            tgt_state = ST_ADR;
            tgt_idx   = idx_reg;
        end
    end

`ifndef VDP_REG_LOADER_SYNC_EN
    logic [3:0] first_sel;
    assign first_sel = next_sel(mask, 4'd0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            from_reg    <= ST_IDLE;
            idx_reg     <= 3'd0;
            cnt_reg     <= 4'd0;
            mask_reg    <= 8'h00;
            v_reg       <= '{default: 8'h00};
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            wr_tick_reg <= 1'b0;
            rd_tick_reg <= 1'b0;
            dout_reg    <= 8'h00;
        end else begin
            state_reg   <= state_next;
            from_reg    <= from_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            mask_reg    <= mask_next;
            v_reg       <= v_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            wr_tick_reg <= wr_tick_next;
            rd_tick_reg <= rd_tick_next;
            dout_reg    <= dout_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        from_next  = from_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
`ifdef VDP_REG_LOADER_SYNC_EN
                    state_next = ST_SYNC;
                    idx_next   = 3'd0;
`else
                    state_next = first_sel[3] ? ST_DONE : ST_VAL;
                    idx_next   = first_sel[2:0];
`endif
                end
            end
            ST_SYNC, ST_VAL, ST_ADR: begin
                from_next = state_reg;
                if (GAP == 0) begin
                    state_next = tgt_state;
                    idx_next   = tgt_idx;
                end else begin
                    state_next = ST_GAP;
                    cnt_next   = 4'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = tgt_state;
                    idx_next   = tgt_idx;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                idx_next   = 3'd0;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        busy_next    = (state_next == ST_SYNC) || (state_next == ST_VAL) ||
                       (state_next == ST_ADR)  || (state_next == ST_GAP);
        done_next    = (state_next == ST_DONE);
        wr_tick_next = (state_next == ST_VAL) || (state_next == ST_ADR);
`ifdef VDP_REG_LOADER_SYNC_EN
        rd_tick_next = (state_next == ST_SYNC);
`else
        rd_tick_next = 1'b0;
`endif
        dout_next = 8'h00;
        if (state_next == ST_VAL) begin
            dout_next = v_next[idx_next];
        end else if (state_next == ST_ADR) begin
            dout_next = {WR_REG_SIG, 3'b000, idx_next};
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign wr_tick = wr_tick_reg;
    assign rd_tick = rd_tick_reg;
    assign dout    = dout_reg;

endmodule

// File: tb/tb_vdp_reg_loader.sv
// Randomized bench for vdp_reg_loader: GAP=0 and GAP=3 instances share stimulus and are
// compared cycle by cycle against a tick-list timeline model and a byte-pair receiver model.
module tb_vdp_reg_loader;

`ifdef VDP_REG_LOADER_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [7:0] v0 = 8'h00, v1 = 8'h00, v2 = 8'h00, v3 = 8'h00;
    logic [7:0] v4 = 8'h00, v5 = 8'h00, v6 = 8'h00, v7 = 8'h00;

    logic       busy_a, done_a, wr_a, rd_a;
    logic [7:0] dout_a;
    logic       busy_b, done_b, wr_b, rd_b;
    logic [7:0] dout_b;

    always #5 clk = ~clk;

    vdp_reg_loader #(.GAP(0)) dut_g0 (
        .clk(clk), .reset(reset), .start(start), .mask(mask),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
        .busy(busy_a), .done(done_a), .wr_tick(wr_a), .rd_tick(rd_a), .dout(dout_a)
    );

    vdp_reg_loader #(.GAP(3)) dut_g3 (
        .clk(clk), .reset(reset), .start(start), .mask(mask),
        .v0(v0), .v1(v1), .v2(v2), .v3(v3), .v4(v4), .v5(v5), .v6(v6), .v7(v7),
        .busy(busy_b), .done(done_b), .wr_tick(wr_b), .rd_tick(rd_b), .dout(dout_b)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Expected {busy, done, wr_tick, rd_tick, dout} per cycle after acceptance.
    logic [11:0] exp_tr [2][80];
    logic [7:0]  rf     [2][2][8];
    logic [7:0]  hold   [2][2];
    bit          tog    [2][2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] obs(input int d);
        if (d == 0) return {busy_a, done_a, wr_a, rd_a, dout_a};
        return {busy_b, done_b, wr_b, rd_b, dout_b};
    endfunction

    task automatic build(input int d, input int gap, input logic [7:0] m, input logic [7:0] vv [8]);
        logic [8:0] q[$];
        int t;
        for (int c = 0; c < 80; c++) exp_tr[d][c] = 12'h000;
        if (SYNC_EN) q.push_back({1'b1, 8'h00});
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                q.push_back({1'b0, vv[i]});
                q.push_back({1'b0, 8'h80 | 8'(i)});
            end
        end
        t = 1;
        foreach (q[k]) begin
            exp_tr[d][t] = {1'b1, 1'b0, ~q[k][8], q[k][8], q[k][7:0]};
            for (int g = 1; g <= gap; g++) exp_tr[d][t + g] = 12'h800;
            t += gap + 1;
        end
        exp_tr[d][t] = 12'h400;
    endtask

    task automatic rx(input int d, input int s, input logic [11:0] o);
        if (o[8]) begin
            tog[d][s] = 1'b0;
        end else if (o[9]) begin
            if (!tog[d][s]) begin
                hold[d][s] = o[7:0];
                tog[d][s]  = 1'b1;
            end else begin
                if (o[7:6] == 2'b10) rf[d][s][o[2:0]] = hold[d][s];
                tog[d][s] = 1'b0;
            end
        end
    endtask

    task automatic drive_v(input logic [7:0] vv [8]);
        v0 = vv[0]; v1 = vv[1]; v2 = vv[2]; v3 = vv[3];
        v4 = vv[4]; v5 = vv[5]; v6 = vv[6]; v7 = vv[7];
    endtask

    task automatic scramble_inputs();
        logic [7:0] rv [8];
        foreach (rv[k]) rv[k] = 8'($urandom);
        mask = 8'($urandom);
        drive_v(rv);
    endtask

    task automatic run_seq(input string name, input logic [7:0] m, input logic [7:0] vv [8],
                           input bit midstart, input int rst_at);
        logic [11:0] e, o;
        logic [63:0] pe, po;
        @(negedge clk);
        reset = 1'b0;
        mask  = m;
        drive_v(vv);
        start = 1'b1;
        build(0, 0, m, vv);
        build(1, 3, m, vv);
        @(posedge clk);
        #1;
        start = midstart;
        scramble_inputs();
        for (int c = 1; c < 80; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                o = obs(d);
                e = (rst_at > 0 && c >= rst_at) ? 12'h000 : exp_tr[d][c];
                if (rst_at > 0 && c == rst_at) begin
                    tog[d][0] = 1'b0;
                    tog[d][1] = 1'b0;
                end
                check($sformatf("%s.gap%0d.cyc%0d", name, d * 3, c), 64'(o), 64'(e));
                rx(d, 0, e);
                rx(d, 1, o);
            end
            start = 1'b0;
            reset = (rst_at > 0 && c == rst_at - 1);
            scramble_inputs();
        end
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 8; k++) begin
                pe[k*8 +: 8] = rf[d][0][k];
                po[k*8 +: 8] = rf[d][1][k];
            end
            check($sformatf("%s.gap%0d.regfile", name, d * 3), po, pe);
        end
        $display("[TB] seq %s mask=%02h midstart=%0d reset_at=%0d", name, m, midstart, rst_at);
    endtask

    initial begin
        logic [7:0] va [8];
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 2; s++) begin
                tog[d][s]  = 1'b0;
                hold[d][s] = 8'h00;
                for (int k = 0; k < 8; k++) rf[d][s][k] = 8'h00;
            end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.gap0", 64'(obs(0)), 64'h0);
        check("reset.gap3", 64'(obs(1)), 64'h0);

        foreach (va[k]) va[k] = 8'($urandom);
        va[0] = 8'h02;
        run_seq("single", 8'h01, va, 1'b0, 0);

        foreach (va[k]) va[k] = 8'($urandom);
        va[0] = 8'hAA;
        va[7] = 8'h55;
        run_seq("pair07", 8'h81, va, 1'b0, 0);

        run_seq("empty", 8'h00, va, 1'b0, 0);

        foreach (va[k]) va[k] = 8'h10 + 8'(k);
        run_seq("all", 8'hFF, va, 1'b0, 0);

        foreach (va[k]) va[k] = 8'($urandom);
        run_seq("restart", 8'($urandom) | 8'h08, va, 1'b1, 0);

        run_seq("empty_restart", 8'h00, va, 1'b1, 0);

        foreach (va[k]) va[k] = 8'($urandom);
        run_seq("abort", 8'hFF, va, 1'b0, 10);

        for (int n = 0; n < 20; n++) begin
            foreach (va[k]) va[k] = 8'($urandom);
            run_seq($sformatf("rand%0d", n), 8'($urandom), va, 1'($urandom_range(1)),
                    ($urandom_range(3) == 0) ? int'($urandom_range(60, 2)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
